// File: rtl/key_irq_ctrl.sv
// key_irq_ctrl: four debounced active-low keys with auto-repeat, a pending
// register and a fixed-priority interrupt requester (IDLE/REQ/SVC handshake).
module key_irq_ctrl #(
   parameter int unsigned DEB_TICKS = 4,
   parameter int unsigned REP_DLY   = 32,
   parameter int unsigned REP_RATE  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic [3:0] keys_n,
   input  logic       ei,
   input  logic       di,
   input  logic       ack,
   output logic       irq,
   output logic [7:0] vector,
   output logic [3:0] key_state,
   output logic       ien
);

   localparam int unsigned NK = 4;
   localparam int unsigned CW = 8;
   localparam logic [CW-1:0] DEB_M1      = CW'(DEB_TICKS - 1);
   localparam logic [CW-1:0] REP_DLY_M1  = CW'(REP_DLY - 1);
   localparam logic [CW-1:0] REP_RATE_M1 = CW'(REP_RATE - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SVC} state_t;

   logic [NK-1:0] r_sync1;
   logic [NK-1:0] r_sync2;
   logic [NK-1:0] r_key_state;
   logic [NK-1:0] r_ks_prev;
   logic [CW-1:0] r_deb_cnt [NK];
   logic [CW-1:0] r_rep_cnt [NK];
   logic [NK-1:0] r_rep_phase;
   logic [NK-1:0] r_pend;
   state_t        r_state;
   logic [1:0]    r_idx;
   logic          r_irq;
   logic [7:0]    r_vector;
   logic          r_ien;

   logic [NK-1:0] w_lvl;
   logic [NK-1:0] w_press;
   logic [NK-1:0] w_rep_hit;
   logic [NK-1:0] w_evt;
   logic [NK-1:0] w_clr;
   logic [1:0]    w_win_idx;
   logic          w_ien_eff;

   assign w_lvl     = ~r_sync2;
   assign w_press   = r_key_state & ~r_ks_prev;
   assign w_evt     = w_press | w_rep_hit;
   // di wins over ei; used only while idle
   assign w_ien_eff = di ? 1'b0 : (ei ? 1'b1 : r_ien);

   assign irq       = r_irq;
   assign vector    = r_vector;
   assign key_state = r_key_state;
   assign ien       = r_ien;

   // Two-flop synchronizer, resets to released (1)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
      end else begin
         r_sync1 <= keys_n;
         r_sync2 <= r_sync1;
      end
   end

   // Debounce: flip level after DEB_TICKS consecutive differing ticks
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_key_state <= '0;
         for (int k = 0; k < NK; k++) r_deb_cnt[k] <= '0;
      end else if (tick) begin
         for (int k = 0; k < NK; k++) begin
            if (w_lvl[k] != r_key_state[k]) begin
               if (r_deb_cnt[k] == DEB_M1) begin
                  r_deb_cnt[k]   <= '0;
                  r_key_state[k] <= ~r_key_state[k];
               end else begin
                  r_deb_cnt[k] <= r_deb_cnt[k] + CW'(1);
               end
            end else begin
               r_deb_cnt[k] <= '0;
            end
         end
      end
   end

   // Delayed copy of debounced level for press-edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_ks_prev <= '0;
      else     r_ks_prev <= r_key_state;
   end

   // Repeat hit: counting starts the tick after the press event
   always_comb begin
      w_rep_hit = '0;
      for (int k = 0; k < NK; k++) begin
         if (tick && r_key_state[k] && r_ks_prev[k] &&
             (r_rep_cnt[k] == (r_rep_phase[k] ? REP_RATE_M1 : REP_DLY_M1)))
            w_rep_hit[k] = 1'b1;
      end
   end

   // Repeat counters: initial delay phase, then rate phase; saturate, clear on release
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rep_phase <= '0;
         for (int k = 0; k < NK; k++) r_rep_cnt[k] <= '0;
      end else begin
         for (int k = 0; k < NK; k++) begin
            if (!r_key_state[k]) begin
               r_rep_cnt[k]   <= '0;
               r_rep_phase[k] <= 1'b0;
            end else if (tick && r_ks_prev[k]) begin
               if (w_rep_hit[k]) begin
                  r_rep_cnt[k]   <= '0;
                  r_rep_phase[k] <= 1'b1;
               end else if (r_rep_cnt[k] != '1) begin
                  r_rep_cnt[k] <= r_rep_cnt[k] + CW'(1);
               end
            end
         end
      end
   end

   // Fixed priority winner, key 0 highest
   always_comb begin
      w_win_idx = 2'd3;
      if (r_pend[2]) w_win_idx = 2'd2;
      if (r_pend[1]) w_win_idx = 2'd1;
      if (r_pend[0]) w_win_idx = 2'd0;
   end

   // Pending clear on accepted request
   always_comb begin
      w_clr = '0;
      if (r_state == ST_REQ && ack) w_clr[r_idx] = 1'b1;
   end

   // Pending register: a same-cycle event overrides the clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_pend <= '0;
      else     r_pend <= (r_pend & ~w_clr) | w_evt;
   end

   // Request FSM with registered irq/vector/ien
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_idx    <= 2'd0;
         r_irq    <= 1'b0;
         r_vector <= 8'd0;
         r_ien    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_ien <= w_ien_eff;
               if (w_ien_eff && (r_pend != '0)) begin
                  r_idx    <= w_win_idx;
                  r_irq    <= 1'b1;
                  r_vector <= 8'd2 + {5'd0, w_win_idx, 1'b0};
                  r_state  <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (ack) begin
                  r_irq    <= 1'b0;
                  r_vector <= 8'd0;
                  r_ien    <= 1'b0;
                  r_state  <= ST_SVC;
               end
            end
            ST_SVC: begin
               if (ei) begin
                  r_ien   <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_key_irq_ctrl.sv
// Directed bench for key_irq_ctrl with default parameters and tick held high.
module tb_key_irq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick;
   logic [3:0] keys_n;
   logic       ei;
   logic       di;
   logic       ack;
   logic       irq;
   logic [7:0] vector;
   logic [3:0] key_state;
   logic       ien;

   int errors = 0;
   int checks = 0;

   key_irq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .keys_n    (keys_n),
      .ei        (ei),
      .di        (di),
      .ack       (ack),
      .irq       (irq),
      .vector    (vector),
      .key_state (key_state),
      .ien       (ien)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Advance n clocks, land 1 ns after the rising edge
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; tick = 1'b1; keys_n = 4'hF; ei = 1'b0; di = 1'b0; ack = 1'b0;
      #2;
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
      checks++; if (vector !== 8'd0) begin errors++; $display("FAIL reset_vector: got %0d want 0", vector); end
      checks++; if (key_state !== 4'h0) begin errors++; $display("FAIL reset_key_state: got %b want 0000", key_state); end
      checks++; if (ien !== 1'b0) begin errors++; $display("FAIL reset_ien: got %b want 0", ien); end
      step(2);
      rst = 1'b0;
      step(2);
   endtask

   task automatic test_debounce_irq();
      ei = 1'b1; step(1); ei = 1'b0;
      checks++; if (ien !== 1'b1) begin errors++; $display("FAIL ei_idle: ien got %b want 1", ien); end
      keys_n = 4'b1011;
      step(5);
      checks++; if (key_state !== 4'b0000) begin errors++; $display("FAIL deb_early: got %b want 0000", key_state); end
      step(1);
      checks++; if (key_state !== 4'b0100) begin errors++; $display("FAIL deb_set: got %b want 0100", key_state); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early0: got %b want 0", irq); end
      step(1);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early1: got %b want 0", irq); end
      step(1);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_key2: got %b want 1", irq); end
      checks++; if (vector !== 8'd6) begin errors++; $display("FAIL vec_key2: got %0d want 6", vector); end
      step(2);
      keys_n = 4'hF;
      di = 1'b1; step(1); di = 1'b0;
      checks++; if (irq !== 1'b1 || vector !== 8'd6) begin errors++; $display("FAIL req_stable: irq %b vec %0d want 1/6", irq, vector); end
      ack = 1'b1; step(1); ack = 1'b0;
      checks++; if (irq !== 1'b0 || vector !== 8'd0) begin errors++; $display("FAIL ack_drop: irq %b vec %0d want 0/0", irq, vector); end
      checks++; if (ien !== 1'b0) begin errors++; $display("FAIL ack_ien: got %b want 0", ien); end
      ei = 1'b1; step(1); ei = 1'b0;
      checks++; if (ien !== 1'b1) begin errors++; $display("FAIL svc_ei: ien got %b want 1", ien); end
      step(10);
      checks++; if (key_state !== 4'h0 || irq !== 1'b0) begin errors++; $display("FAIL release_quiet: ks %b irq %b want 0000/0", key_state, irq); end
   endtask

   task automatic test_glitch();
      keys_n = 4'b1101;
      step(3);
      keys_n = 4'hF;
      for (int i = 0; i < 15; i++) begin
         step(1);
         checks++;
         if (key_state !== 4'h0 || irq !== 1'b0) begin
            errors++; $display("FAIL glitch_c%0d: ks %b irq %b want 0000/0", i, key_state, irq);
         end
      end
   endtask

   task automatic test_priority();
      int found;
      found = 0;
      keys_n = 4'b0110;
      for (int i = 1; i <= 20; i++) begin
         step(1);
         if (irq === 1'b1) begin found = i; break; end
      end
      checks++; if (found != 8) begin errors++; $display("FAIL prio_latency: irq at cycle %0d want 8", found); end
      checks++; if (vector !== 8'd2) begin errors++; $display("FAIL prio_first: vec %0d want 2", vector); end
      keys_n = 4'hF;
      ack = 1'b1; step(1); ack = 1'b0;
      step(3);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL svc_ignores_pend: irq %b want 0", irq); end
      ei = 1'b1; step(1); ei = 1'b0;
      step(1);
      checks++; if (irq !== 1'b1 || vector !== 8'd8) begin errors++; $display("FAIL prio_second: irq %b vec %0d want 1/8", irq, vector); end
      ack = 1'b1; step(1); ack = 1'b0;
      ei = 1'b1; step(1); ei = 1'b0;
      step(10);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL prio_drained: irq %b want 0", irq); end
   endtask

   task automatic test_repeat();
      int exp_t [5] = '{8, 40, 48, 56, 64};
      int n;
      n = 0;
      keys_n = 4'b1110;
      for (int cyc = 1; cyc <= 100; cyc++) begin
         step(1);
         if (cyc == 60) keys_n = 4'hF;
         if (ack) begin
            ack = 1'b0; ei = 1'b1;
         end else if (ei) begin
            ei = 1'b0;
         end else if (irq === 1'b1) begin
            checks++;
            if (n >= 5) begin
               errors++; $display("FAIL rep_extra: irq at cycle %0d", cyc);
            end else if (cyc != exp_t[n] || vector !== 8'd2) begin
               errors++; $display("FAIL rep_%0d: cycle %0d vec %0d want %0d/2", n, cyc, vector, exp_t[n]);
            end
            n++;
            ack = 1'b1;
         end
      end
      checks++; if (n != 5) begin errors++; $display("FAIL rep_count: got %0d want 5", n); end
   endtask

   task automatic test_ien();
      di = 1'b1; step(1); di = 1'b0;
      checks++; if (ien !== 1'b0) begin errors++; $display("FAIL di_idle: ien %b want 0", ien); end
      keys_n = 4'b1101;
      step(10);
      keys_n = 4'hF;
      step(10);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL masked: irq %b want 0", irq); end
      ei = 1'b1; step(1); ei = 1'b0;
      checks++; if (irq !== 1'b1 || vector !== 8'd4) begin errors++; $display("FAIL ei_grant: irq %b vec %0d want 1/4", irq, vector); end
      checks++; if (ien !== 1'b1) begin errors++; $display("FAIL ei_grant_ien: ien %b want 1", ien); end
      ack = 1'b1; step(1); ack = 1'b0;
      di = 1'b1; step(1); di = 1'b0;
      checks++; if (ien !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL di_svc: ien %b irq %b want 0/0", ien, irq); end
      ei = 1'b1; step(1); ei = 1'b0;
      checks++; if (ien !== 1'b1) begin errors++; $display("FAIL svc_exit: ien %b want 1", ien); end
      ei = 1'b1; di = 1'b1; step(1); ei = 1'b0; di = 1'b0;
      checks++; if (ien !== 1'b0) begin errors++; $display("FAIL ei_di_both: ien %b want 0", ien); end
      ack = 1'b1; step(1); ack = 1'b0;
      checks++; if (ien !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL ack_idle: ien %b irq %b want 0/0", ien, irq); end
   endtask

   task automatic test_reset_in_req();
      int found;
      found = 0;
      ei = 1'b1; step(1); ei = 1'b0;
      keys_n = 4'b1011;
      for (int i = 1; i <= 20; i++) begin
         step(1);
         if (irq === 1'b1) begin found = i; break; end
      end
      checks++; if (found == 0 || vector !== 8'd6) begin errors++; $display("FAIL rr_req: cycle %0d vec %0d want irq/6", found, vector); end
      keys_n = 4'hF;
      #2;
      rst = 1'b1;
      #1;
      checks++; if (irq !== 1'b0 || vector !== 8'd0) begin errors++; $display("FAIL rr_async: irq %b vec %0d want 0/0", irq, vector); end
      checks++; if (ien !== 1'b0 || key_state !== 4'h0) begin errors++; $display("FAIL rr_ien_ks: ien %b ks %b want 0/0000", ien, key_state); end
      checks++; if (dut.r_pend !== 4'h0) begin errors++; $display("FAIL rr_pend: got %b want 0000", dut.r_pend); end
      step(1);
      rst = 1'b0;
      step(10);
      ei = 1'b1; step(1); ei = 1'b0;
      step(3);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rr_discarded: irq %b want 0", irq); end
   endtask

   initial begin
      test_reset();
      test_debounce_irq();
      test_glitch();
      test_priority();
      test_repeat();
      test_ien();
      test_reset_in_req();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/key_irq_ctrl.md
KEY_IRQ_CTRL -- requirements
Module: key_irq_ctrl

Interface
REQ-001 SHALL have parameter DEB_TICKS, default 4, meaning consecutive equal samples (in ticks) needed to change a debounced key level, legal range 1..255.
REQ-002 SHALL have parameter REP_DLY, default 32, meaning ticks a key must stay held after its press event before the first repeat event, range 1..255.
REQ-003 SHALL have parameter REP_RATE, default 8, meaning ticks between subsequent repeat events while held, range 1..255.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-006 SHALL have port tick, input, 1, meaning a one-cycle sample strobe; debounce and repeat counters advance only on cycles with tick=1.
REQ-007 SHALL have port keys_n, input, 4, meaning raw asynchronous buttons, active-low (0 = pressed).
REQ-008 SHALL have port ei, input, 1, meaning a one-cycle pulse that enables interrupts.
REQ-009 SHALL have port di, input, 1, meaning a one-cycle pulse that disables interrupts.
REQ-010 SHALL have port ack, input, 1, meaning a one-cycle pulse from the CPU accepting the current request.
REQ-011 SHALL have port irq, output, 1, meaning an interrupt request is pending toward the CPU.
REQ-012 SHALL have port vector, output, 8, meaning the jump address of the request: 2+2*k for winning key k (2, 4, 6, 8).
REQ-013 SHALL have port key_state, output, 4, meaning debounced key levels, active-high (1 = held).
REQ-014 SHALL have port ien, output, 1, meaning interrupt enable flag.

Function
REQ-015 SHALL pass each keys_n bit through a 2-flop synchronizer before any other use.
REQ-016 SHALL flip key_state[k] only after DEB_TICKS consecutive ticks on which the synchronized level differs from key_state[k]; any tick that matches key_state[k] resets the count to 0.
REQ-017 SHALL generate a press event for key k in the cycle key_state[k] goes 0->1; release produces no event.
REQ-018 SHALL, while key_state[k]=1, generate a repeat event REP_DLY ticks after the press event, then every REP_RATE ticks; the 8-bit repeat counter restarts on release and does not wrap while held.
REQ-019 SHALL hold a 4-bit pending register: an event sets pending[k] on the next clock; pending[k] clears only when its request is acked; an event on the ack cycle for the same key leaves pending[k]=1.
REQ-020 SHALL arbitrate with fixed priority, key 0 highest, key 3 lowest.
REQ-021 SHALL implement states IDLE, REQ, SVC.
REQ-022 IDLE: when ien=1 and pending!=0, SHALL latch the winner index, set irq=1 and vector=2+2*index on the next clock, and go to REQ.
REQ-023 REQ: irq and vector SHALL stay stable regardless of new events or di until ack=1; on ack SHALL clear pending[index], irq=0, ien=0, go to SVC.
REQ-024 SVC: SHALL ignore pending; on ei=1 SHALL set ien=1 and go to IDLE.
REQ-025 ei in IDLE SHALL set ien=1; di in IDLE SHALL clear ien=0; ei and di together SHALL leave ien=0 (di wins); di in SVC SHALL have no effect.
REQ-026 ack outside REQ SHALL be ignored.
REQ-027 vector SHALL read 0 whenever irq=0.

Reset
REQ-028 rst=1 SHALL immediately force state=IDLE, irq=0, vector=0, ien=0, pending=0, key_state=0, all counters 0, synchronizer flops to 1 (released).
REQ-029 Deassertion of rst SHALL produce no key events, even if keys are held (they debounce in from released).
REQ-030 rst asserted in REQ SHALL drop irq asynchronously and discard the request.

Verification
REQ-031 tick=1 every cycle, ien=1, key 2 pressed 10 cycles -> key_state[2]=1 after sync+4 ticks, irq=1 with vector=6 two cycles later.
REQ-032 key 1 pressed 3 ticks then released -> key_state stays 0, no irq.
REQ-033 keys 3 and 0 pressed same cycle, ien=1 -> first request vector=2; after ack+ei, second request vector=8.
REQ-034 key 0 held 60 ticks, each ack followed by ei -> requests at press, +32 ticks, +40 ticks, +48, +56 ticks.
REQ-035 ien=0, key 1 pressed -> no irq; ei pulse -> irq=1 vector=4 next cycle; ei+di same cycle in IDLE -> ien=0.
REQ-036 rst pulse while irq=1 -> irq=0, vector=0, ien=0, pending=0 without clock edge.
